// File: rtl/mem_access_unit.sv
// Memory-stage access unit: a two-state sequencer that issues data-memory
// requests for loads and stores, stalls the pipeline, and retires into MEM/WB.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    input  logic        mem_to_reg_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    // state | meaning
    // IDLE  | accept a new instruction; ALU results and misaligned ops retire next cycle
    // BUSY  | memory request outstanding; wait for ack or give up at the timeout cycle
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The timeout cycle is the last BUSY cycle in which an ack is still honoured.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic        m2r_q;

    logic        mem_op;
    logic        aligned;
    logic        timeout;
    logic        latch_en;
    logic        wb_fire;
    logic        wb_rw_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;
    logic        err_set;
    logic        stall;
    logic        req;

    assign mem_op  = mem_read_i | mem_write_i;
    assign aligned = (addr_i[1:0] == 2'b00);
    assign timeout = (cnt_q == LAST_WAIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        wb_fire   = 1'b0;
        wb_rw_d   = 1'b0;
        wb_rd_d   = wb_rd_o;
        wb_data_d = wb_data_o;
        err_set   = 1'b0;
        stall     = 1'b0;
        req       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (valid_i && !mem_op) begin
                    wb_fire   = 1'b1;
                    wb_data_d = addr_i;
                    wb_rd_d   = rd_i;
                    wb_rw_d   = reg_write_i;
                end else if (valid_i && !aligned) begin
                    wb_fire   = 1'b1;
                    wb_data_d = addr_i;
                    wb_rd_d   = rd_i;
                    err_set   = 1'b1;
                end else if (valid_i) begin
                    stall    = 1'b1;
                    latch_en = 1'b1;
                    state_d  = BUSY;
                end
            end

            BUSY: begin
                req = 1'b1;
                if (dmem_ack_i) begin
                    wb_fire   = 1'b1;
                    wb_data_d = (!we_q && m2r_q) ? dmem_rdata_i : addr_q;
                    wb_rd_d   = rd_q;
                    wb_rw_d   = rw_q & ~we_q;
                    state_d   = IDLE;
                end else if (timeout) begin
                    wb_fire   = 1'b1;
                    wb_data_d = addr_q;
                    wb_rd_d   = rd_q;
                    err_set   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= mem_write_i;
            rd_q    <= rd_i;
            rw_q    <= reg_write_i;
            m2r_q   <= mem_to_reg_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= 5'd0;
            wb_data_o      <= 32'd0;
            err_o          <= 1'b0;
        end else begin
            wb_valid_o     <= wb_fire;
            wb_reg_write_o <= wb_rw_d;
            wb_rd_o        <= wb_rd_d;
            wb_data_o      <= wb_data_d;
            err_o          <= err_o | err_set;
        end
    end

    // Reset gates the combinational stall so it drops in the same cycle reset asserts.
    assign stall_o      = stall & rst_i;
    assign dmem_req_o   = req & rst_i;
    assign dmem_we_o    = dmem_req_o & we_q;
    assign dmem_addr_o  = dmem_req_o ? addr_q  : 32'd0;
    assign dmem_wdata_o = dmem_req_o ? wdata_q : 32'd0;

endmodule
